// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike memory-bus fabric.
//   t_bus_state     : fabric FSM states (IDLE, ACCESS, RESP)
//   BUS_BE_W        : byte-enable width of the 32-bit core bus
//   BUS_MAX_REGIONS : upper bound on the number of decoded slave regions
//   t_bus_req       : one core request as seen on the 32-bit core bus
package risc_v_mike_pkg;

  localparam int DATA_32_W       = 32;
  localparam int ADDR_32_W       = 32;
  localparam int BUS_BE_W        = DATA_32_W / 8;
  localparam int BUS_MAX_REGIONS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } t_bus_state;

  typedef struct packed {
    logic [ADDR_32_W-1:0] addr;
    logic                 write;
    logic [DATA_32_W-1:0] wdata;
    logic [BUS_BE_W-1:0]  be;
  } t_bus_req;

endpackage

// File: rtl/risc_v_mike_bus_decode.sv
// Combinational region decoder.
//   addr : byte address to decode
//   hit  : one-hot region hit; when regions overlap the lowest index wins
//   miss : no region matched
// Region i matches when (addr & mask_i) == base_i, where base_i and mask_i
// occupy bits [i*ADDR_W +: ADDR_W] of REGION_BASE / REGION_MASK.
module risc_v_mike_bus_decode
  import risc_v_mike_pkg::*;
#(
  parameter int                            NUM_REGIONS = 4,
  parameter int                            ADDR_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic                   miss
);

  // Walk from the highest index down so the lowest matching index is the
  // last writer and therefore wins.
  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit    = '0;
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/risc_v_mike_bus_fabric.sv
// Memory-bus fabric between the multicycle core and its slave regions.
// Decodes one request at a time into a one-hot slave select, waits for the
// selected slave's ready, and returns a one-cycle registered response.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   req_*           : core request (valid/ready, addr, write, wdata, be)
//   resp_*          : one-cycle response pulse with rdata / error
//   slv_sel/..._be  : registered slave-side request, held during ACCESS
//   slv_ready/rdata : per-region completion and packed read data
//   dbg_state       : current FSM state
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, so at most one
// transaction is in flight; request inputs are ignored until the next IDLE.
//
// Optional macro BUS_TIMEOUT_EN: abort an ACCESS with an error after
// TIMEOUT_CYCLES cycles without slave ready.
module risc_v_mike_bus_fabric
  import risc_v_mike_pkg::*;
#(
  parameter int                            NUM_REGIONS    = 4,
  parameter int                            ADDR_W         = 32,
  parameter int                            DATA_W         = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    =
    {32'hFFFF0000, 32'h00400000, 32'h7FFFE000, 32'h10010000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK    =
    {32'hFFFFFF00, 32'hFFC00000, 32'hFFFFE000, 32'hFFFF0000},
  parameter int                            TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_write,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_be,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_error,
  output logic [NUM_REGIONS-1:0]        slv_sel,
  output logic                          slv_write,
  output logic [ADDR_W-1:0]             slv_addr,
  output logic [DATA_W-1:0]             slv_wdata,
  output logic [DATA_W/8-1:0]           slv_be,
  input  logic [NUM_REGIONS-1:0]        slv_ready,
  input  logic [NUM_REGIONS*DATA_W-1:0] slv_rdata,
  output t_bus_state                    dbg_state
);

  localparam int BE_W = DATA_W / 8;

  t_bus_state              state, state_nxt;
  logic [NUM_REGIONS-1:0]  dec_hit;
  logic                    dec_miss;
  logic                    req_err;
  logic [ADDR_W-1:0]       hit_mask;
  logic [DATA_W-1:0]       sel_rdata;
  logic                    sel_ready;
  logic                    timeout;

  logic [NUM_REGIONS-1:0]  sel_q;
  logic                    write_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [BE_W-1:0]         be_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  risc_v_mike_bus_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr (req_addr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  // Unmapped and non-word-aligned requests never reach a slave.
  assign req_err = dec_miss || (req_addr[1:0] != 2'b00);

  // Ready bits of unselected regions are masked off here.
  assign sel_ready = |(slv_ready & sel_q);

  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (dec_hit[i]) hit_mask = REGION_MASK[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q[i]) sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside ACCESS, so it is cleared on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tmo_cnt <= '0;
    else if (state != ACCESS) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Slave ready in the last allowed cycle still wins over the timeout.
  assign timeout = (state == ACCESS) && !sel_ready &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  if (sel_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave-side request and response registers. The response registers are
  // zero everywhere except during the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              err_q <= 1'b1;
            end else begin
              sel_q   <= dec_hit;
              write_q <= req_write;
              addr_q  <= req_addr & ~hit_mask;
              wdata_q <= req_wdata;
              be_q    <= req_write ? req_be : '1;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            sel_q   <= '0;
            rdata_q <= write_q ? '0 : sel_rdata;
          end else if (timeout) begin
            sel_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          sel_q <= '0;
        end
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;
  assign slv_sel    = sel_q;
  assign slv_write  = write_q;
  assign slv_addr   = addr_q;
  assign slv_wdata  = wdata_q;
  assign slv_be     = be_q;
  assign dbg_state  = state;

endmodule
